// File: rtl/uart_responder.sv
// uart_responder: device-side stand-in for the board UART chip.
// Accepts CPU byte writes on the wrn strobe and sends them as 8N1 frames on
// txd. Receives 8N1 frames on rxd into a one-byte buffer, which the CPU
// reads back with the rdn strobe. Status is polled through data_ready, tbre
// and tsre.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   wrn         write strobe, active-low (acts on its falling edge)
//   rdn         read strobe, active-low (read completes on its rising edge)
//   data_in     byte to transmit, sampled on a write event
//   data_out    receive buffer, refreshed every cycle rdn is low
//   data_oe     bus drive enable, registered copy of (rdn == 0)
//   data_ready  receive buffer holds an unread byte
//   tbre        transmit holding register empty
//   tsre        transmit shift register empty (line idle)
//   rxd         asynchronous serial input
//   txd         serial output, idle high
//
// TX FSM
//   state  | meaning
//   IDLE   | line idle, waiting for the holding register to fill
//   START  | driving the start bit (0)
//   DATA   | driving 8 data bits, LSB first
//   STOP   | driving the stop bit (1); chains straight into the next frame
//
// RX FSM
//   state  | meaning
//   IDLE   | waiting for rxs to fall
//   START  | timing to mid start bit; a high sample there is a glitch
//   DATA   | sampling 8 data bits at mid-bit, LSB first
//   STOP   | sampling the stop bit; a low sample is a framing error
module uart_responder #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wrn,
  input  logic       rdn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  // Bit timers are down-counters loaded with (period - 1); the state acts
  // on the cycle it observes zero, giving exactly `period` cycles per bit.
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- strobes
  logic wrn_q, rdn_q;
  logic write_ev, read_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wrn_q <= 1'b1;
      rdn_q <= 1'b1;
    end else begin
      wrn_q <= wrn;
      rdn_q <= rdn;
    end
  end

  assign write_ev  = wrn_q & ~wrn;
  assign read_done = ~rdn_q & rdn;

  // ---------------------------------------------------------------- TX path
  tx_state_t        tx_state, tx_state_d;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_d;
  logic [2:0]       tx_idx, tx_idx_d;
  logic [7:0]       tx_shift, tx_shift_d;
  logic [7:0]       tx_hold, tx_hold_d;
  logic             tbre_d, tsre_d, txd_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_hold  <= '0;
      tbre     <= 1'b1;
      tsre     <= 1'b1;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_idx   <= tx_idx_d;
      tx_shift <= tx_shift_d;
      tx_hold  <= tx_hold_d;
      tbre     <= tbre_d;
      tsre     <= tsre_d;
      txd      <= txd_d;
    end
  end

  // A write (needs tbre=1) and a hold->shifter transfer (needs tbre=0) can
  // never fall on the same edge, so the two updates of tbre do not collide.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_idx_d   = tx_idx;
    tx_shift_d = tx_shift;
    tx_hold_d  = tx_hold;
    tbre_d     = tbre;
    tsre_d     = tsre;
    txd_d      = txd;

    if (write_ev && tbre) begin
      tx_hold_d = data_in;
      tbre_d    = 1'b0;
    end

    case (tx_state)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (!tbre) begin
          tx_shift_d = tx_hold;
          tbre_d     = 1'b1;
          tsre_d     = 1'b0;
          txd_d      = 1'b0;
          tx_cnt_d   = BIT_LAST;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_cnt_d   = BIT_LAST;
          tx_idx_d   = 3'd0;
          txd_d      = tx_shift[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_d = BIT_LAST;
          if (tx_idx == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            // Shift right so the next bit to send is always in bit 1.
            tx_shift_d = {1'b0, tx_shift[7:1]};
            txd_d      = tx_shift[1];
            tx_idx_d   = tx_idx + 3'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (!tbre) begin
            // Queued byte: start the next frame with no idle gap.
            tx_shift_d = tx_hold;
            tbre_d     = 1'b1;
            txd_d      = 1'b0;
            tx_cnt_d   = BIT_LAST;
            tx_state_d = TX_START;
          end else begin
            tsre_d     = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt - CNT_ONE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- RX path
  logic             rx_meta, rxs;
  rx_state_t        rx_state, rx_state_d;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_d;
  logic [2:0]       rx_idx, rx_idx_d;
  logic [7:0]       rx_shift, rx_shift_d;
  logic [7:0]       rx_buf, rx_buf_d;
  logic             data_ready_d;
  logic             rx_done;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta    <= 1'b1;
      rxs        <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_shift   <= '0;
      rx_buf     <= '0;
      data_ready <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rxs        <= rx_meta;
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_idx     <= rx_idx_d;
      rx_shift   <= rx_shift_d;
      rx_buf     <= rx_buf_d;
      data_ready <= data_ready_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    rx_idx_d     = rx_idx;
    rx_shift_d   = rx_shift;
    rx_buf_d     = rx_buf;
    data_ready_d = data_ready;
    rx_done      = 1'b0;

    case (rx_state)
      RX_IDLE: begin
        if (!rxs) begin
          rx_cnt_d   = HALF_LAST;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (rxs) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_cnt_d   = BIT_LAST;
            rx_idx_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_d = {rxs, rx_shift[7:1]};
          rx_cnt_d   = BIT_LAST;
          if (rx_idx == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_idx_d = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (rxs) begin
            rx_buf_d = rx_shift;
            rx_done  = 1'b1;
          end
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt - CNT_ONE;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase

    // A completing byte beats a simultaneous read-done so it is not lost.
    if (rx_done) begin
      data_ready_d = 1'b1;
    end else if (read_done) begin
      data_ready_d = 1'b0;
    end
  end

  // -------------------------------------------------------------- read path
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_oe  <= 1'b0;
      data_out <= '0;
    end else begin
      data_oe <= ~rdn;
      if (!rdn) begin
        data_out <= rx_buf;
      end
    end
  end

endmodule

// File: tb/tb_uart_responder.sv
module tb_uart_responder;

  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       wrn = 1'b1;
  logic       rdn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe, data_ready, tbre, tsre, txd;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  uart_responder #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .wrn(wrn), .rdn(rdn), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .rxd(rxd), .txd(txd)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line level of bit j (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j >= 9) return 1'b1;
    return b[j-1];
  endfunction

  // All tasks are entered at a negedge and return at a negedge.
  task automatic do_write(input logic [7:0] b);
    wrn = 1'b0;
    data_in = b;
    @(negedge CLK);
    wrn = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    for (int j = 0; j < 10; j++) begin
      rxd = (j == 9) ? stop_bit : frame_bit(b, j);
      repeat (CPB) @(negedge CLK);
    end
    rxd = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic do_read(input logic [7:0] exp, input string tag);
    rdn = 1'b0;
    @(negedge CLK);
    check({tag, "_oe"}, data_oe, 1'b1);
    check({tag, "_data"}, data_out, exp);
    repeat (2) @(negedge CLK);
    rdn = 1'b1;
    @(negedge CLK);
    check({tag, "_ready_clr"}, data_ready, 1'b0);
    check({tag, "_oe_off"}, data_oe, 1'b0);
  endtask

  // Independent TX line decoder: samples txd mid-bit and collects bytes.
  logic       mon_en = 1'b0;
  logic [7:0] mon_q[$];
  int         mon_stop_err = 0;

  initial begin
    logic [7:0] mb;
    mb = 8'h00;
    forever begin
      @(negedge CLK);
      if (mon_en && txd === 1'b0) begin
        repeat (CPB / 2) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          mb[i] = txd;
        end
        repeat (CPB) @(negedge CLK);
        if (txd !== 1'b1) mon_stop_err++;
        mon_q.push_back(mb);
      end
    end
  end

  typedef struct {
    logic [7:0] rx_byte;
    logic       stop_bit;
    logic       do_rd;
    logic       exp_ready;
    logic [7:0] exp_out;
  } rx_vec_t;

  rx_vec_t    vec[7];
  logic [7:0] exp_q[$];
  logic [7:0] m_buf;
  logic       m_ready;

  initial begin
    int acc_e, rel_r, chain_start, line_end;
    logic [7:0] b;
    logic st, rd;

    vec[0] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C};
    vec[1] = '{8'h5A, 1'b0, 1'b0, 1'b0, 8'h00};  // framing error: dropped
    vec[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h00};
    vec[3] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22};  // overrun of 0x11
    vec[4] = '{8'h99, 1'b0, 1'b1, 1'b0, 8'h22};  // dropped, buffer keeps 0x22
    vec[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    vec[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF};

    // ---------------- reset
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_txd", txd, 1'b1);
    check("rst_tbre", tbre, 1'b1);
    check("rst_tsre", tsre, 1'b1);
    check("rst_ready", data_ready, 1'b0);
    check("rst_oe", data_oe, 1'b0);
    check("rst_dout", data_out, 8'h00);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // ---------------- start-bit glitch
    rxd = 1'b0;
    repeat (4) @(negedge CLK);
    rxd = 1'b1;
    repeat (40) @(negedge CLK);
    check("glitch_ready", data_ready, 1'b0);

    // ---------------- receive table
    foreach (vec[i]) begin
      send_frame(vec[i].rx_byte, vec[i].stop_bit);
      check($sformatf("rxvec%0d_ready", i), data_ready, vec[i].exp_ready);
      if (vec[i].do_rd) do_read(vec[i].exp_out, $sformatf("rxvec%0d", i));
    end

    // ---------------- single transmit 0xA5
    do_write(8'hA5);
    check("tx1_tbre_low", tbre, 1'b0);
    for (int k = 1; k <= 161; k++) begin
      @(negedge CLK);
      if (k <= 160) check($sformatf("tx1_txd k=%0d", k), txd, frame_bit(8'hA5, (k - 1) / CPB));
      if (k == 1) begin
        check("tx1_tbre_back", tbre, 1'b1);
        check("tx1_tsre_low", tsre, 1'b0);
      end
      if (k == 160) check("tx1_tsre_k160", tsre, 1'b0);
      if (k == 161) check("tx1_tsre_k161", tsre, 1'b1);
    end
    repeat (5) @(negedge CLK);

    // ---------------- back-to-back 0x01 then 0xFF, third write ignored
    do_write(8'h01);
    for (int k = 1; k <= 360; k++) begin
      @(negedge CLK);
      if (k <= 160)
        check($sformatf("b2b_txd k=%0d", k), txd, frame_bit(8'h01, (k - 1) / CPB));
      else if (k <= 320)
        check($sformatf("b2b_txd k=%0d", k), txd, frame_bit(8'hFF, (k - 161) / CPB));
      else
        check($sformatf("b2b_idle k=%0d", k), txd, 1'b1);
      check($sformatf("b2b_tsre k=%0d", k), tsre, (k <= 320) ? 1'b0 : 1'b1);
      if (k == 41 || k == 46) check($sformatf("b2b_tbre k=%0d", k), tbre, 1'b0);
      if (k == 161) check("b2b_tbre_xfer", tbre, 1'b1);
      if (k == 40) begin wrn = 1'b0; data_in = 8'hFF; end
      if (k == 41) wrn = 1'b1;
      if (k == 45) begin wrn = 1'b0; data_in = 8'hAA; end
      if (k == 46) wrn = 1'b1;
    end

    // ---------------- reset mid-frame
    send_frame(8'h77, 1'b1);
    check("pre_rst_ready", data_ready, 1'b1);
    do_write(8'h33);
    rxd = 1'b0;
    repeat (60) @(negedge CLK);
    RST = 1'b1;
    rdn = 1'b0;
    rxd = 1'b1;
    @(negedge CLK);
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_tbre", tbre, 1'b1);
    check("mid_rst_tsre", tsre, 1'b1);
    check("mid_rst_ready", data_ready, 1'b0);
    check("mid_rst_oe", data_oe, 1'b0);
    check("mid_rst_dout", data_out, 8'h00);
    RST = 1'b0;
    rdn = 1'b1;
    repeat (3) @(negedge CLK);
    fork
      begin
        do_write(8'h55);
        check("post_rst_tbre", tbre, 1'b0);
        for (int k = 1; k <= 161; k++) begin
          @(negedge CLK);
          if (k <= 160) check($sformatf("post_rst_txd k=%0d", k), txd, frame_bit(8'h55, (k - 1) / CPB));
          if (k == 161) check("post_rst_tsre", tsre, 1'b1);
        end
      end
      send_frame(8'h55, 1'b1);
    join
    check("post_rst_ready", data_ready, 1'b1);
    do_read(8'h55, "post_rst_rd");

    // ---------------- random transmit against a timing/scoreboard model
    // Model: a write at edge E is taken if the holding register is free;
    // its frame starts at max(E+1, end of current frame) and lasts 10 bits.
    repeat (5) @(negedge CLK);
    mon_q.delete();
    exp_q.delete();
    mon_en = 1'b1;
    acc_e = -10;
    rel_r = -10;
    chain_start = 0;
    line_end = 0;
    for (int c = 1; c <= 3000 || c <= line_end + 4; c++) begin
      @(negedge CLK);
      check($sformatf("rnd_tbre c=%0d", c), tbre, !(c >= acc_e && c < rel_r));
      check($sformatf("rnd_tsre c=%0d", c), tsre, !(c >= chain_start && c < line_end));
      if (wrn == 1'b0) begin
        wrn = 1'b1;
      end else if (c < 3000 && $urandom_range(0, 39) == 0) begin
        b = 8'($urandom);
        wrn = 1'b0;
        data_in = b;
        if (!((c >= acc_e) && (c < rel_r))) begin
          acc_e = c + 1;
          rel_r = (c + 2 > line_end) ? c + 2 : line_end;
          if (rel_r > line_end) chain_start = rel_r;
          line_end = rel_r + 10 * CPB;
          exp_q.push_back(b);
        end
      end
    end
    mon_en = 1'b0;
    check("rnd_frame_count", mon_q.size(), exp_q.size());
    check("rnd_stop_errors", mon_stop_err, 0);
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++)
      check($sformatf("rnd_byte%0d", i), mon_q[i], exp_q[i]);

    // ---------------- random receive against a buffer model
    m_buf = 8'h55;
    m_ready = 1'b0;
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      rd = $urandom_range(0, 1) == 1;
      send_frame(b, st);
      if (st) begin
        m_buf = b;
        m_ready = 1'b1;
      end
      check($sformatf("rndrx%0d_ready", n), data_ready, m_ready);
      if (rd) begin
        do_read(m_buf, $sformatf("rndrx%0d", n));
        m_ready = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
